axi_rd_arb: RTL and testbench
=============================

AXI_RD_ARB -- requirements
Module: axi_rd_arb

Interface
REQ-001 param N_PORTS, default 2, number of read clients, legal range 1..16; port 0 is instruction fetch and port 1 is the LSU.
REQ-002 param ADDR_W, default 64, address width.
REQ-003 param DATA_W, default 64, R data width.
REQ-004 param ID_W, default 4, AXI ID width; elaboration SHALL fail unless N_PORTS <= 2**ID_W.
REQ-005 clk  in  1  clock; all logic on the rising edge.
REQ-006 rstn  in  1  reset, synchronous, active-low.
REQ-007 req_valid  in  N_PORTS  per-port read request.
REQ-008 req_addr  in  N_PORTS*ADDR_W  per-port address; port p occupies slice p.
REQ-009 req_size  in  N_PORTS*3  per-port AXI size code.
REQ-010 req_ready  out  N_PORTS  request accepted this cycle; one-hot or zero.
REQ-011 rsp_valid  out  N_PORTS  one-cycle response strobe; one-hot or zero.
REQ-012 rsp_data  out  DATA_W  response data, shared by all ports, qualified by rsp_valid.
REQ-013 rsp_err  out  1  RRESP was not OKAY, qualified by rsp_valid.
REQ-014 ARID, ARADDR, ARLEN(8), ARSIZE(3), ARBURST(2), ARVALID  out  AXI read-address channel.
REQ-015 ARREADY  in  1  AXI read-address ready.
REQ-016 RID, RDATA, RRESP(2), RLAST, RVALID  in  AXI read-data channel.
REQ-017 RREADY  out  1  AXI read-data ready.

Function
REQ-018 Arbitration SHALL be round-robin: search starts at last_grant+1 (mod N_PORTS); a port is eligible only if req_valid is set and it has no read in flight.
REQ-019 Request acceptance: when the AR slot is empty and an eligible port exists, req_ready[p] SHALL pulse for one cycle, and AR fields SHALL register on the next edge with ARVALID=1, ARID=p, ARADDR/ARSIZE from port p, ARLEN=0, ARBURST=INCR(01).
REQ-020 All AR outputs SHALL hold stable while ARVALID=1 and ARREADY=0; the slot SHALL free on the ARVALID&&ARREADY edge.
REQ-021 On the cycle the slot frees, a new grant MAY be issued, so back-to-back AR SHALL be sustained at one per 2 cycles minimum.
REQ-022 Each port SHALL have an inflight[p] flag, set at grant and cleared when RVALID&&RREADY&&RLAST&&RID==p.
REQ-023 Up to N_PORTS reads SHALL be outstanding; responses MAY return out of order across IDs.
REQ-024 RREADY SHALL be 1 whenever rstn=1.
REQ-025 Response: on RVALID&&RLAST, rsp_valid[RID], rsp_data=RDATA and rsp_err=(RRESP!=00) SHALL be driven combinationally in the same cycle, with zero latency.
REQ-026 A response with RID >= N_PORTS, or with inflight[RID]=0, SHALL be consumed and dropped, and no rsp_valid bit SHALL assert.
REQ-027 A grant and a response for the same port in the same cycle SHALL NOT occur, because inflight blocks the grant; a response for port p and a grant for port q!=p in the same cycle SHALL both complete.
REQ-028 When req_valid deasserts before grant, no AR SHALL be issued for it; when req_valid deasserts after grant, the read SHALL still complete and rsp_valid SHALL still pulse.

Reset
REQ-029 While rstn=0: ARVALID=0, RREADY=0, req_ready=0, all inflight=0, last_grant=N_PORTS-1, and AR fields=0.
REQ-030 Reset mid-transaction SHALL abandon all outstanding IDs; late R beats after reset SHALL be dropped per REQ-026.

Structure
REQ-031 The shared package axi_pkg SHALL hold the AxSIZE, AxBURST and xRESP encodings and the AXI channel widths.
REQ-032 The round-robin picker SHALL be a sub-module rr_arbiter with parameter N, inputs req and last, and outputs gnt (one-hot) and any.

Verification
REQ-033 Reset release, port0 req addr 0x80000000 size 2 -> ARVALID next cycle, ARID=0, ARADDR=0x80000000, ARSIZE=2; RDATA 0x13 RID=0 -> rsp_valid=01, rsp_data=0x13, rsp_err=0.
REQ-034 Both ports requesting continuously, ARREADY=1 -> ARID alternates 0,1,0,1.
REQ-035 ARREADY held 0 for 5 cycles -> AR fields unchanged throughout and req_ready=0 for all ports.
REQ-036 Port0 and port1 both in flight, R returns RID=1 then RID=0 -> rsp_valid=10 then 01 with matching data.
REQ-037 RRESP=10 on RID=1 -> rsp_valid=10, rsp_err=1, inflight[1] cleared; unsolicited RID=3 -> no rsp_valid.
REQ-038 rstn pulsed low while both ports in flight -> outputs at reset values; next request from port0 is granted normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings and channel widths used by the read-side blocks.
package axi_pkg;

  localparam int unsigned AxiLenW   = 8;
  localparam int unsigned AxiSizeW  = 3;
  localparam int unsigned AxiBurstW = 2;
  localparam int unsigned AxiRespW  = 2;

  typedef enum logic [AxiSizeW-1:0] {
    Size1B   = 3'd0,
    Size2B   = 3'd1,
    Size4B   = 3'd2,
    Size8B   = 3'd3,
    Size16B  = 3'd4,
    Size32B  = 3'd5,
    Size64B  = 3'd6,
    Size128B = 3'd7
  } axi_size_e;

  typedef enum logic [AxiBurstW-1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10
  } axi_burst_e;

  typedef enum logic [AxiRespW-1:0] {
    RespOkay   = 2'b00,
    RespExOkay = 2'b01,
    RespSlvErr = 2'b10,
    RespDecErr = 2'b11
  } axi_resp_e;

  function automatic logic resp_is_err(logic [AxiRespW-1:0] resp);
    return resp != RespOkay;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: searches from last+1 (mod N) and grants the first requester.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] last,
  output logic [N-1:0]    gnt,
  output logic            any
);

  logic [IdxW-1:0] idx;
  logic            found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = IdxW'((32'(last) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/axi_rd_arb.sv
// Multi-client AXI read arbiter: one AR slot, single-beat reads, one outstanding read per port.
module axi_rd_arb
  import axi_pkg::*;
#(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ID_W    = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N_PORTS-1:0]        req_valid,
  input  logic [N_PORTS*ADDR_W-1:0] req_addr,
  input  logic [N_PORTS*3-1:0]      req_size,
  output logic [N_PORTS-1:0]        req_ready,
  output logic [N_PORTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic [ID_W-1:0]           ARID,
  output logic [ADDR_W-1:0]         ARADDR,
  output logic [AxiLenW-1:0]        ARLEN,
  output logic [AxiSizeW-1:0]       ARSIZE,
  output logic [AxiBurstW-1:0]      ARBURST,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  input  logic [ID_W-1:0]           RID,
  input  logic [DATA_W-1:0]         RDATA,
  input  logic [AxiRespW-1:0]       RRESP,
  input  logic                      RLAST,
  input  logic                      RVALID,
  output logic                      RREADY
);

  if (N_PORTS < 1 || N_PORTS > 16 || N_PORTS > (1 << ID_W)) begin : g_bad_params
    $fatal(1, "axi_rd_arb: N_PORTS must be 1..16 and no larger than 2**ID_W");
  end

  localparam int unsigned IdxW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [N_PORTS-1:0]   inflight_q, inflight_d;
  logic [IdxW-1:0]      last_q, last_d;
  logic                 ar_valid_q, ar_valid_d;
  logic [ID_W-1:0]      ar_id_q, ar_id_d;
  logic [ADDR_W-1:0]    ar_addr_q, ar_addr_d;
  logic [AxiSizeW-1:0]  ar_size_q, ar_size_d;
  logic [AxiBurstW-1:0] ar_burst_q, ar_burst_d;

  logic [N_PORTS-1:0]   eligible, gnt, grant;
  logic                 gnt_any, grant_en, r_done;
  logic [IdxW-1:0]      gnt_idx;
  logic [ADDR_W-1:0]    gnt_addr;
  logic [AxiSizeW-1:0]  gnt_size;

  // A port with a read in flight cannot be granted again until its R beat returns.
  assign eligible = req_valid & ~inflight_q;

  rr_arbiter #(
    .N(N_PORTS)
  ) u_rr (
    .req  (eligible),
    .last (last_q),
    .gnt  (gnt),
    .any  (gnt_any)
  );

  assign grant_en  = rstn && !ar_valid_q && gnt_any;
  assign grant     = grant_en ? gnt : '0;
  assign req_ready = grant;

  always_comb begin
    gnt_idx  = '0;
    gnt_addr = '0;
    gnt_size = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      if (gnt[p]) begin
        gnt_idx  = IdxW'(p);
        gnt_addr = req_addr[p*ADDR_W +: ADDR_W];
        gnt_size = req_size[p*3 +: 3];
      end
    end
  end

  // R is always accepted; beats for unknown or idle IDs are consumed silently.
  assign RREADY = rstn;
  assign r_done = RVALID && RREADY && RLAST;

  always_comb begin
    rsp_valid = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      rsp_valid[p] = r_done && inflight_q[p] && (RID == ID_W'(p));
    end
  end

  assign rsp_data = RDATA;
  assign rsp_err  = resp_is_err(RRESP);

  always_comb begin
    inflight_d = (inflight_q | grant) & ~rsp_valid;
    last_d     = grant_en ? gnt_idx : last_q;
    ar_valid_d = ar_valid_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    if (ar_valid_q && ARREADY) begin
      ar_valid_d = 1'b0;
    end
    if (grant_en) begin
      ar_valid_d = 1'b1;
      ar_id_d    = ID_W'(gnt_idx);
      ar_addr_d  = gnt_addr;
      ar_size_d  = gnt_size;
      ar_burst_d = BurstIncr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      inflight_q <= '0;
      last_q     <= IdxW'(N_PORTS - 1);
      ar_valid_q <= 1'b0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      last_q     <= last_d;
      ar_valid_q <= ar_valid_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
    end
  end

  assign ARVALID = ar_valid_q;
  assign ARID    = ar_id_q;
  assign ARADDR  = ar_addr_q;
  assign ARSIZE  = ar_size_q;
  assign ARBURST = ar_burst_q;
  assign ARLEN   = '0;

endmodule

// File: tb/tb_axi_rd_arb.sv
// Directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_axi_rd_arb;

  localparam int unsigned NP = 2;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic [NP-1:0]    req_valid;
  logic [NP*AW-1:0] req_addr;
  logic [NP*3-1:0]  req_size;
  logic [NP-1:0]    req_ready;
  logic [NP-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic             rsp_err;
  logic [IW-1:0]    ARID;
  logic [AW-1:0]    ARADDR;
  logic [7:0]       ARLEN;
  logic [2:0]       ARSIZE;
  logic [1:0]       ARBURST;
  logic             ARVALID;
  logic             ARREADY;
  logic [IW-1:0]    RID;
  logic [DW-1:0]    RDATA;
  logic [1:0]       RRESP;
  logic             RLAST;
  logic             RVALID;
  logic             RREADY;

  always #5 clk = ~clk;

  axi_rd_arb #(
    .N_PORTS(NP),
    .ADDR_W (AW),
    .DATA_W (DW),
    .ID_W   (IW)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_size (req_size),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .ARID     (ARID),
    .ARADDR   (ARADDR),
    .ARLEN    (ARLEN),
    .ARSIZE   (ARSIZE),
    .ARBURST  (ARBURST),
    .ARVALID  (ARVALID),
    .ARREADY  (ARREADY),
    .RID      (RID),
    .RDATA    (RDATA),
    .RRESP    (RRESP),
    .RLAST    (RLAST),
    .RVALID   (RVALID),
    .RREADY   (RREADY)
  );

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: who is waiting for data, who was served last, what sits on AR.
  bit          m_inflight[NP];
  int          m_last;
  bit          m_arv;
  logic [63:0] m_arid, m_araddr, m_arsize, m_arburst;
  int          acc_q[$];
  int          hs_ids[$];

  logic [NP-1:0] obs_req_ready, obs_rsp_valid;
  logic [DW-1:0] obs_rsp_data;
  logic          obs_rsp_err, obs_rready, obs_arvalid;
  logic [63:0]   obs_arid, obs_araddr, obs_arsize;

  function automatic void model_reset();
    for (int p = 0; p < NP; p++) m_inflight[p] = 1'b0;
    m_last = NP - 1;
    m_arv = 1'b0;
    m_arid = '0;
    m_araddr = '0;
    m_arsize = '0;
    m_arburst = '0;
    acc_q.delete();
  endfunction

  task automatic set_idle();
    req_valid = '0;
    ARREADY = 1'b0;
    RVALID = 1'b0;
    RLAST = 1'b0;
    RID = '0;
    RDATA = '0;
    RRESP = '0;
  endtask

  task automatic drive_r(input int id, input logic [DW-1:0] data, input logic [1:0] resp);
    RVALID = 1'b1;
    RLAST = 1'b1;
    RID = IW'(id);
    RDATA = data;
    RRESP = resp;
  endtask

  // One clock: compare at negedge against the model, then advance the model at posedge.
  task automatic tick();
    int g, r;
    logic [NP-1:0] exp_rdy, exp_rsp;
    @(negedge clk);
    g = -1;
    if (rstn && !m_arv) begin
      for (int i = 1; i <= NP; i++) begin
        int p;
        p = (m_last + i) % NP;
        if (g < 0 && req_valid[p] && !m_inflight[p]) g = p;
      end
    end
    r = -1;
    if (rstn && RVALID && RLAST && RID < NP && m_inflight[RID]) r = int'(RID);
    exp_rdy = (g >= 0) ? (NP'(1) << g) : '0;
    exp_rsp = (r >= 0) ? (NP'(1) << r) : '0;
    check_eq("req_ready", req_ready, exp_rdy);
    check_eq("rsp_valid", rsp_valid, exp_rsp);
    check_eq("rready", RREADY, rstn);
    check_eq("arvalid", ARVALID, m_arv);
    check_eq("arid", ARID, m_arid);
    check_eq("araddr", ARADDR, m_araddr);
    check_eq("arsize", ARSIZE, m_arsize);
    check_eq("arburst", ARBURST, m_arburst);
    check_eq("arlen", ARLEN, 0);
    if (r >= 0) begin
      check_eq("rsp_data", rsp_data, RDATA);
      check_eq("rsp_err", rsp_err, RRESP != 2'b00);
    end
    obs_req_ready = req_ready;
    obs_rsp_valid = rsp_valid;
    obs_rsp_data = rsp_data;
    obs_rsp_err = rsp_err;
    obs_rready = RREADY;
    obs_arvalid = ARVALID;
    obs_arid = 64'(ARID);
    obs_araddr = ARADDR;
    obs_arsize = 64'(ARSIZE);
    if (rstn && ARVALID && ARREADY) hs_ids.push_back(int'(ARID));
    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else begin
      if (m_arv && ARREADY) begin
        acc_q.push_back(int'(m_arid));
        m_arv = 1'b0;
      end
      if (g >= 0) begin
        m_arv = 1'b1;
        m_arid = 64'(g);
        m_araddr = req_addr[g*AW +: AW];
        m_arsize = 64'(req_size[g*3 +: 3]);
        m_arburst = 64'd1;
        m_inflight[g] = 1'b1;
        m_last = g;
      end
      if (r >= 0) begin
        m_inflight[r] = 1'b0;
        for (int k = 0; k < acc_q.size(); k++) begin
          if (acc_q[k] == r) begin
            acc_q.delete(k);
            break;
          end
        end
      end
    end
    #1;
  endtask

  task automatic drain();
    req_valid = '0;
    ARREADY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (acc_q.size() > 0) drive_r(acc_q[0], DW'(64'h1000 + i), 2'b00);
      else RVALID = 1'b0;
      tick();
    end
    set_idle();
  endtask

  task automatic reset_pulse();
    set_idle();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] cap_addr, cap_id;
    set_idle();
    req_addr = '0;
    req_size = '0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    tick();
    check_eq("rst_arvalid", obs_arvalid, 0);
    check_eq("rst_rready", obs_rready, 0);
    check_eq("rst_req_ready", obs_req_ready, 0);
    check_eq("rst_araddr", obs_araddr, 0);
    rstn = 1'b1;

    // Single read from port 0.
    req_valid = 2'b01;
    req_addr[0 +: AW] = 64'h8000_0000;
    req_size[2:0] = 3'd2;
    tick();
    check_eq("t1_ready", obs_req_ready, 2'b01);
    req_valid = '0;
    ARREADY = 1'b1;
    tick();
    check_eq("t1_arvalid", obs_arvalid, 1);
    check_eq("t1_arid", obs_arid, 0);
    check_eq("t1_araddr", obs_araddr, 64'h8000_0000);
    check_eq("t1_arsize", obs_arsize, 2);
    ARREADY = 1'b0;
    drive_r(0, 64'h13, 2'b00);
    tick();
    check_eq("t1_rsp_valid", obs_rsp_valid, 2'b01);
    check_eq("t1_rsp_data", obs_rsp_data, 64'h13);
    check_eq("t1_rsp_err", obs_rsp_err, 0);
    set_idle();
    tick();

    // Continuous requests from both ports with prompt responses.
    reset_pulse();
    hs_ids.delete();
    req_valid = 2'b11;
    req_addr[0 +: AW] = 64'h100;
    req_addr[AW +: AW] = 64'h200;
    ARREADY = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (acc_q.size() > 0) drive_r(acc_q[0], DW'(64'h500 + i), 2'b00);
      else RVALID = 1'b0;
      tick();
    end
    check_eq("rr_hs_count", hs_ids.size() >= 4, 1);
    if (hs_ids.size() >= 4) begin
      check_eq("rr_id0", hs_ids[0], 0);
      check_eq("rr_id1", hs_ids[1], 1);
      check_eq("rr_id2", hs_ids[2], 0);
      check_eq("rr_id3", hs_ids[3], 1);
    end
    drain();

    // AR stall: fields hold and nothing else is accepted.
    req_valid = 2'b11;
    ARREADY = 1'b0;
    tick();
    tick();
    cap_addr = obs_araddr;
    cap_id = obs_arid;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_araddr", obs_araddr, cap_addr);
      check_eq("stall_arid", obs_arid, cap_id);
      check_eq("stall_arvalid", obs_arvalid, 1);
      check_eq("stall_ready", obs_req_ready, 0);
    end
    drain();

    // Both in flight, responses return out of order.
    req_valid = 2'b11;
    ARREADY = 1'b1;
    repeat (4) tick();
    set_idle();
    check_eq("ooo_outstanding", acc_q.size(), 2);
    drive_r(1, 64'hAAAA, 2'b00);
    tick();
    check_eq("ooo_rsp1", obs_rsp_valid, 2'b10);
    check_eq("ooo_data1", obs_rsp_data, 64'hAAAA);
    drive_r(0, 64'hBBBB, 2'b00);
    tick();
    check_eq("ooo_rsp0", obs_rsp_valid, 2'b01);
    check_eq("ooo_data0", obs_rsp_data, 64'hBBBB);
    set_idle();

    // Error response, repeat after completion, and an unsolicited ID.
    req_valid = 2'b10;
    ARREADY = 1'b1;
    tick();
    tick();
    set_idle();
    drive_r(1, 64'h77, 2'b10);
    tick();
    check_eq("err_rsp", obs_rsp_valid, 2'b10);
    check_eq("err_flag", obs_rsp_err, 1);
    drive_r(1, 64'h78, 2'b00);
    tick();
    check_eq("err_cleared", obs_rsp_valid, 0);
    drive_r(3, 64'h79, 2'b00);
    tick();
    check_eq("unsolicited", obs_rsp_valid, 0);
    set_idle();

    // Reset while both ports are outstanding.
    req_valid = 2'b11;
    ARREADY = 1'b1;
    repeat (4) tick();
    set_idle();
    rstn = 1'b0;
    tick();
    tick();
    check_eq("mid_rst_arvalid", obs_arvalid, 0);
    check_eq("mid_rst_rready", obs_rready, 0);
    check_eq("mid_rst_ready", obs_req_ready, 0);
    rstn = 1'b1;
    drive_r(0, 64'hDEAD, 2'b00);
    tick();
    check_eq("late_r_dropped", obs_rsp_valid, 0);
    set_idle();
    req_valid = 2'b01;
    req_addr[0 +: AW] = 64'h4000;
    tick();
    check_eq("post_rst_ready", obs_req_ready, 2'b01);
    req_valid = '0;
    ARREADY = 1'b1;
    tick();
    check_eq("post_rst_arid", obs_arid, 0);
    check_eq("post_rst_araddr", obs_araddr, 64'h4000);
    drain();

    // Randomized traffic, including drops, early deasserts, stray IDs and resets.
    for (int c = 0; c < 3000; c++) begin
      req_valid = NP'($urandom_range(0, 3));
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 3) == 0) begin
          req_addr[p*AW +: AW] = {$urandom, $urandom};
          req_size[p*3 +: 3] = 3'($urandom_range(0, 7));
        end
      end
      ARREADY = ($urandom_range(0, 3) != 0);
      if (acc_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        RID = IW'(acc_q[$urandom_range(0, acc_q.size() - 1)]);
        RVALID = 1'b1;
      end else if ($urandom_range(0, 7) == 0) begin
        RID = IW'($urandom_range(0, 15));
        RVALID = 1'b1;
      end else begin
        RVALID = 1'b0;
      end
      RLAST = ($urandom_range(0, 5) != 0);
      RDATA = {$urandom, $urandom};
      RRESP = 2'($urandom_range(0, 3));
      rstn = ($urandom_range(0, 199) != 0);
      tick();
    end
    rstn = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
